// File: rtl/ram_burst_reader.sv
// Streams a burst of RAM words into a small FIFO with valid/ready output.
// Optional checksum output enabled by defining RAM_BURST_READER_CHECKSUM_EN.
module ram_burst_reader #(
    parameter int DATA_SIZE    = 32,
    parameter int ADDRESS_SIZE = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDRESS_SIZE-1:0] start_address,
    input  logic [ADDRESS_SIZE-1:0] length,
    output logic                    busy,
    output logic                    done,
    output logic                    ram_enable,
    output logic                    ram_read_write,
    output logic [ADDRESS_SIZE-1:0] ram_address,
    input  logic [DATA_SIZE-1:0]    ram_data_out,
    output logic [DATA_SIZE-1:0]    out_data,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef RAM_BURST_READER_CHECKSUM_EN
    ,
    output logic [DATA_SIZE-1:0]    checksum
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] ONE_COUNT  = (PTR_W+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [ADDRESS_SIZE-1:0] r_counter;
    logic [ADDRESS_SIZE-1:0] r_remaining;
    logic [ADDRESS_SIZE-1:0] r_lastAddress;
    logic [DATA_SIZE-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_rdPtr;
    logic [PTR_W-1:0]        r_wrPtr;
    logic [PTR_W:0]          r_count;
    logic                    w_pop;
    logic                    w_space;
    logic                    w_issue;
    logic                    w_lastIssue;
    logic                    w_loadBurst;

    // A full buffer that is popped this cycle frees the slot the new read needs.
    assign w_pop       = (r_count != '0) && out_ready;
    assign w_space     = (r_count != FULL_COUNT) || w_pop;
    assign w_issue     = (r_state == ST_READ) && (r_remaining != '0) && w_space;
    assign w_lastIssue = w_issue && (r_remaining == ADDRESS_SIZE'(1));
    assign w_loadBurst = (r_state == ST_IDLE) && start && (length != '0);

    assign ram_enable     = w_issue;
    assign ram_read_write = 1'b1;
    assign ram_address    = w_issue ? r_counter : r_lastAddress;
    assign out_valid      = (r_count != '0);
    assign out_data       = r_mem[r_rdPtr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_nextState = (length != '0) ? ST_READ : ST_FINISH;
                end
            end
            ST_READ: begin
                if (w_lastIssue) begin
                    w_nextState = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((r_count == '0) || ((r_count == ONE_COUNT) && w_pop)) begin
                    w_nextState = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done        = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Reset clears the buffer contents so out_data reads zero after an abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_counter     <= '0;
            r_remaining   <= '0;
            r_lastAddress <= '0;
            r_rdPtr       <= '0;
            r_wrPtr       <= '0;
            r_count       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_loadBurst) begin
                r_counter   <= start_address;
                r_remaining <= length;
            end else if (w_issue) begin
                r_counter     <= r_counter + ADDRESS_SIZE'(1);
                r_remaining   <= r_remaining - ADDRESS_SIZE'(1);
                r_lastAddress <= r_counter;
            end
            if (w_issue) begin
                r_mem[r_wrPtr] <= ram_data_out;
                r_wrPtr        <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_issue, w_pop})
                2'b10:   r_count <= r_count + ONE_COUNT;
                2'b01:   r_count <= r_count - ONE_COUNT;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef RAM_BURST_READER_CHECKSUM_EN
    logic [DATA_SIZE-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_checksum <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_checksum <= '0;
        end else if (w_issue) begin
            r_checksum <= r_checksum ^ ram_data_out;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_ram_burst_reader.sv
// Self-checking bench for ram_burst_reader: directed and randomized bursts
// compared against a word-queue model of the expected stream.
module tb_ram_burst_reader;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] startAddress;
    logic [15:0] length;
    logic        busy;
    logic        done;
    logic        ramEnable;
    logic        ramReadWrite;
    logic [15:0] ramAddress;
    logic [31:0] ramDataOut;
    logic [31:0] outData;
    logic        outValid;
    logic        outReady;
`ifdef RAM_BURST_READER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] ram [0:65535];
    logic [15:0] lastAddr;
    int          vectors = 0;
    int          miscompares = 0;

    ram_burst_reader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .start_address  (startAddress),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .ram_enable     (ramEnable),
        .ram_read_write (ramReadWrite),
        .ram_address    (ramAddress),
        .ram_data_out   (ramDataOut),
        .out_data       (outData),
        .out_valid      (outValid),
        .out_ready      (outReady)
`ifdef RAM_BURST_READER_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Asynchronous-read RAM: data follows the presented address in the same cycle.
    assign ramDataOut = ram[ramAddress];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // mode 0: out_ready always high; 1: random out_ready; 2: low for holdLow cycles then high.
    task automatic applyStimulus(input logic [15:0] sa, input logic [15:0] len, input int mode, input int holdLow);
        logic [31:0] expWords[$];
        logic [31:0] expSum;
        int          issued;
        int          popped;
        int          occupancy;
        int          dutPops;
        int          dutReads;
        int          t;
        bit          expPop;
        bit          expEn;
        bit          sawDone;

        expSum = 32'h0;
        for (int i = 0; i < int'(len); i++) begin
            expWords.push_back(ram[16'(sa + 16'(i))]);
            expSum ^= ram[16'(sa + 16'(i))];
        end

        start        = 1'b1;
        startAddress = sa;
        length       = len;
        outReady     = (mode == 0);
        stepCycle();

        issued   = 0;
        popped   = 0;
        dutPops  = 0;
        dutReads = 0;
        sawDone  = 1'b0;
        for (t = 0; t < 400; t++) begin
            case (mode)
                0:       outReady = 1'b1;
                1:       outReady = ($urandom_range(0, 3) != 0);
                default: outReady = (t >= holdLow);
            endcase
            start        = 1'($urandom_range(0, 1));
            startAddress = 16'($urandom);
            length       = 16'($urandom);
            #1;

            occupancy = issued - popped;
            expPop    = (occupancy > 0) && outReady;
            expEn     = (issued < int'(len)) && ((occupancy < DEPTH) || expPop);

            if (mode == 2 && t == holdLow) begin
                checkOutput("reads_while_stalled", dutReads, (int'(len) < DEPTH) ? int'(len) : DEPTH);
            end

            checkOutput("busy", busy, 1'b1);
            checkOutput("done", done, popped == int'(len));
            checkOutput("out_valid", outValid, occupancy > 0);
            checkOutput("ram_enable", ramEnable, expEn);
            checkOutput("ram_read_write", ramReadWrite, 1'b1);
            if (expEn) begin
                checkOutput("ram_address", ramAddress, 16'(sa + 16'(issued)));
                lastAddr = 16'(sa + 16'(issued));
            end
            if (expPop) begin
                checkOutput("out_data", outData, expWords[popped]);
            end

            dutReads += int'(ramEnable);
            dutPops  += int'(outValid && outReady);
            issued   += int'(expEn);
            popped   += int'(expPop);

            if (done === 1'b1) begin
                sawDone = 1'b1;
                break;
            end
            stepCycle();
        end

        if (!sawDone) begin
            checkOutput("done_timeout", done, 1'b1);
        end else begin
            checkOutput("words_delivered", dutPops, int'(len));
            if (mode == 0) begin
                checkOutput("burst_latency", t, (len == 16'h0) ? 0 : int'(len) + 1);
            end
`ifdef RAM_BURST_READER_CHECKSUM_EN
            checkOutput("checksum", checksum, expSum);
`endif
        end

        stepCycle();
        start = 1'b0;
        #1;
        checkOutput("idle_busy", busy, 1'b0);
        checkOutput("idle_done", done, 1'b0);
        checkOutput("idle_out_valid", outValid, 1'b0);
        checkOutput("idle_ram_enable", ramEnable, 1'b0);
        checkOutput("idle_ram_address_hold", ramAddress, lastAddr);
    endtask

    // Directed scenarios first, then a run of randomized bursts.
    initial begin
        int reads;
        logic [15:0] sa;
        logic [15:0] len;

        for (int i = 0; i < 65536; i++) begin
            ram[i] = $urandom;
        end
        for (int i = 0; i < 4; i++) begin
            ram[i] = 32'(i);
        end
        ram[16'h0040] = 32'h0F0F0F0F;
        ram[16'h0041] = 32'h00FF00FF;
        lastAddr      = 16'h0;

        reset        = 1'b1;
        start        = 1'b0;
        startAddress = 16'h0;
        length       = 16'h0;
        outReady     = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_out_valid", outValid, 1'b0);
        checkOutput("reset_ram_enable", ramEnable, 1'b0);
        checkOutput("reset_ram_address", ramAddress, 16'h0);
        checkOutput("reset_out_data", outData, 32'h0);
        reset = 1'b0;

        applyStimulus(16'h0000, 16'd4, 0, 0);
        applyStimulus(16'hFFFE, 16'd3, 0, 0);
        applyStimulus(16'h0100, 16'd6, 2, 10);
        applyStimulus(16'h1234, 16'd0, 0, 0);
        applyStimulus(16'h0040, 16'd2, 0, 0);
`ifdef RAM_BURST_READER_CHECKSUM_EN
        checkOutput("checksum_pair", checksum, 32'h0FF00FF0);
`endif

        // Abort an 8-word burst right after its second read lands in the buffer.
        start        = 1'b1;
        startAddress = 16'h0200;
        length       = 16'd8;
        outReady     = 1'b0;
        stepCycle();
        start = 1'b0;
        reads = 0;
        for (int t = 0; t < 50 && reads < 2; t++) begin
            #1;
            if (ramEnable === 1'b1) begin
                reads++;
            end
            stepCycle();
        end
        checkOutput("reads_before_reset", reads, 2);
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_done", done, 1'b0);
        checkOutput("abort_out_valid", outValid, 1'b0);
        checkOutput("abort_out_data", outData, 32'h0);
        checkOutput("abort_ram_address", ramAddress, 16'h0);
        lastAddr = 16'h0;
        for (int t = 0; t < 4; t++) begin
            stepCycle();
            checkOutput("abort_no_done", done, 1'b0);
        end
        applyStimulus(16'h0300, 16'd5, 1, 0);

        for (int n = 0; n < 12; n++) begin
            sa  = 16'($urandom);
            len = 16'($urandom_range(1, 12));
            if (n % 4 == 3) begin
                applyStimulus(sa, len, 2, $urandom_range(5, 9));
            end else begin
                applyStimulus(sa, len, $urandom_range(0, 1), 0);
            end
        end

        $display("[TB] directed and random bursts complete");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
